// File: rtl/regfile_writeback_queue_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// the hardwired-zero register index and the packed writeback entry.
package regfile_writeback_queue_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_match.sv
// Youngest-match selector over the pending writeback entries: reports whether
// a query register is pending and returns the newest data queued for it.
module wbq_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [$clog2(DEPTH):0]       i_count,
  input  logic [ADDR_W-1:0]            i_query,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Slot gi is the gi-th oldest pending entry; it only counts while gi < count.
  logic [DEPTH-1:0][PTR_W-1:0] w_idx;
  logic [DEPTH-1:0]            w_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign w_idx[gi]   = i_head + PTR_W'(gi);
    assign w_match[gi] = (CNT_W'(gi) < i_count) && (i_rd[w_idx[gi]] == i_query);
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; later (younger) matches win.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && (i_query != ADDR_W'(REG_ZERO))) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx[i]];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with a
// two-port lookup that forwards the newest still-pending value per register.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rf_ready,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     RegWrite,
  input  logic [ADDR_W-1:0]        q_rs1,
  input  logic [ADDR_W-1:0]        q_rs2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] r_rd_mem;
  logic [DEPTH-1:0][DATA_W-1:0] r_data_mem;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;

  logic w_nonempty;
  logic w_accept;
  logic w_enq;
  logic w_deq;

  // Ready looks only at registered occupancy, so a full queue stalls one
  // cycle even while it drains; this keeps wb_ready off the rf_ready path.
  assign w_nonempty = (r_count != '0);
  assign wb_ready   = (r_count != CNT_W'(DEPTH));
  assign w_accept   = wb_valid && wb_ready;
  assign w_enq      = w_accept && (wb_rd != ADDR_W'(REG_ZERO));
  assign w_deq      = w_nonempty && rf_ready;

  assign RegWrite  = w_deq;
  assign rd        = w_nonempty ? r_rd_mem[r_head]   : '0;
  assign WriteData = w_nonempty ? r_data_mem[r_head] : '0;
  assign count     = r_count;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry array has no reset; count gates every read, so stale
  // contents are never observable and the storage can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd_mem[r_tail]   <= wb_rd;
      r_data_mem[r_tail] <= wb_data;
    end
  end

  wbq_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match1 (
    .i_rd    (r_rd_mem),
    .i_data  (r_data_mem),
    .i_head  (r_head),
    .i_count (r_count),
    .i_query (q_rs1),
    .o_hit   (hit1),
    .o_data  (fwd1)
  );

  wbq_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match2 (
    .i_rd    (r_rd_mem),
    .i_data  (r_data_mem),
    .i_head  (r_head),
    .i_count (r_count),
    .i_query (q_rs2),
    .o_hit   (hit2),
    .o_data  (fwd2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_regfile_writeback_queue;
  import regfile_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        rf_ready;
  logic [4:0]  rd;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        hit1;
  logic        hit2;
  logic [63:0] fwd1;
  logic [63:0] fwd2;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_entry_t mq[$];

  regfile_writeback_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .rf_ready  (rf_ready),
    .rd        (rd),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .hit1      (hit1),
    .hit2      (hit2),
    .fwd1      (fwd1),
    .fwd2      (fwd2),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending writes are a plain queue, oldest first.
  initial begin : model
    bit e_we, e_ready, e_hit1, e_hit2, do_enq, do_deq;
    logic [4:0]  e_rd;
    logic [63:0] e_wd, e_f1, e_f2;
    forever begin
      @(negedge clk);
      if (!reset) mq.delete();
      e_ready = (mq.size() < DEPTH);
      e_we    = (mq.size() > 0) && rf_ready;
      e_rd    = (mq.size() > 0) ? mq[0].rd   : 5'd0;
      e_wd    = (mq.size() > 0) ? mq[0].data : 64'd0;
      e_hit1 = 0; e_f1 = '0; e_hit2 = 0; e_f2 = '0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!e_hit1 && q_rs1 != 5'd0 && mq[k].rd == q_rs1) begin e_hit1 = 1; e_f1 = mq[k].data; end
        if (!e_hit2 && q_rs2 != 5'd0 && mq[k].rd == q_rs2) begin e_hit2 = 1; e_f2 = mq[k].data; end
      end
      check("m_count",     count,     64'(mq.size()));
      check("m_wb_ready",  wb_ready,  e_ready);
      check("m_RegWrite",  RegWrite,  e_we);
      check("m_rd",        rd,        e_rd);
      check("m_WriteData", WriteData, e_wd);
      check("m_hit1",      hit1,      e_hit1);
      check("m_fwd1",      fwd1,      e_f1);
      check("m_hit2",      hit2,      e_hit2);
      check("m_fwd2",      fwd2,      e_f2);
      do_deq = reset && e_we;
      do_enq = reset && wb_valid && e_ready && (wb_rd != 5'd0);
      @(posedge clk);
      if (reset) begin
        if (do_deq) void'(mq.pop_front());
        if (do_enq) mq.push_back('{rd: wb_rd, data: wb_data});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h99;
    rf_ready = 1'b1; q_rs1 = 5'd5; q_rs2 = 5'd0;

    // Reset held with a request present: nothing accepted, idle outputs.
    repeat (3) tick();
    @(negedge clk);
    check("rst_RegWrite", RegWrite, 0);
    check("rst_wb_ready", wb_ready, 1);
    check("rst_count", count, 0);
    check("rst_hit1", hit1, 0);
    check("rst_WriteData", WriteData, 0);

    tick();
    reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h55;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("first_RegWrite", RegWrite, 1);
    check("first_rd", rd, 5);
    check("first_WriteData", WriteData, 64'h55);
    tick();
    @(negedge clk);
    check("first_drained", count, 0);

    // Fill to full, hold the fifth request, then drain in order.
    tick();
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 64'(i * 'h11);
      tick();
    end
    wb_rd = 5'd5; wb_data = 64'h55;
    @(negedge clk);
    check("full_count", count, 4);
    check("full_wb_ready", wb_ready, 0);
    tick();
    @(negedge clk);
    check("full_held_count", count, 4);
    tick();
    rf_ready = 1'b1;
    @(negedge clk);
    check("drain1_rd", rd, 1);
    check("drain1_WriteData", WriteData, 64'h11);
    tick();
    @(negedge clk);
    check("drain2_rd", rd, 2);
    check("drain2_count", count, 3);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("fifth_accepted_count", count, 3);
    repeat (4) tick();
    @(negedge clk);
    check("fill_empty", count, 0);

    // Two pending writes to the same register: the younger one forwards.
    tick();
    rf_ready = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'hA;
    tick();
    wb_data = 64'hB;
    tick();
    wb_valid = 1'b0; q_rs1 = 5'd7; q_rs2 = 5'd0;
    @(negedge clk);
    check("fwd_hit1", hit1, 1);
    check("fwd_fwd1", fwd1, 64'hB);
    check("fwd_hit2", hit2, 0);
    check("fwd_fwd2", fwd2, 0);
    tick();
    rf_ready = 1'b1;
    repeat (2) tick();

    // Writes to register zero are swallowed.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("zero_count", count, 0);
    check("zero_RegWrite", RegWrite, 0);

    // Steady state at count 2 with simultaneous enqueue/dequeue past wrap.
    tick();
    rf_ready = 1'b0; wb_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_rd = 5'(i + 1); wb_data = {$urandom, $urandom};
      tick();
    end
    rf_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wb_rd = 5'($urandom_range(1, 31)); wb_data = {$urandom, $urandom};
      q_rs1 = wb_rd; q_rs2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      check("steady_count", count, 2);
      tick();
    end
    wb_valid = 1'b0;
    repeat (3) tick();

    // Reset mid-operation discards pending entries.
    rf_ready = 1'b0; wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_rd = 5'(i + 10); wb_data = 64'(i + 'h100);
      tick();
    end
    wb_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_count", count, 3);
    tick();
    reset = 1'b0; rf_ready = 1'b1;
    @(negedge clk);
    check("mid_reset_count", count, 0);
    check("mid_reset_RegWrite", RegWrite, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_RegWrite", RegWrite, 0);
      tick();
    end

    // Randomized traffic against the model, narrow index range for hits.
    for (int i = 0; i < 600; i++) begin
      wb_valid = ($urandom_range(0, 99) < 60);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = {$urandom, $urandom};
      rf_ready = ($urandom_range(0, 99) < 55);
      q_rs1    = 5'($urandom_range(0, 7));
      q_rs2    = 5'($urandom_range(0, 7));
      tick();
    end
    wb_valid = 1'b0; rf_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("final_empty", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Writer side of the 64-bit, 32-entry register file write port.
- Accepts writeback requests from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the register file's rd, WriteData and RegWrite inputs, one write per cycle, whenever the register file can take it.
- Provides a two-port forwarding lookup so readers get the newest value still pending in the queue.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, register index width (32 architectural registers).
- DEPTH, 4, queue entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- wb_valid  input  1  writeback request present.
- wb_ready  output  1  queue can accept a request this cycle.
- wb_rd  input  ADDR_W  destination register of the request.
- wb_data  input  DATA_W  value to write.
- rf_ready  input  1  register file write port available this cycle.
- rd  output  ADDR_W  destination index to the register file.
- WriteData  output  DATA_W  data to the register file.
- RegWrite  output  1  register file write enable.
- q_rs1  input  ADDR_W  forwarding lookup index, port 1.
- q_rs2  input  ADDR_W  forwarding lookup index, port 2.
- hit1  output  1  q_rs1 matches a pending entry.
- hit2  output  1  q_rs2 matches a pending entry.
- fwd1  output  DATA_W  newest pending data for q_rs1; 0 when no hit.
- fwd2  output  DATA_W  newest pending data for q_rs2; 0 when no hit.
- count  output  clog2(DEPTH)+1  number of pending entries.

Behaviour:
- State: DEPTH-entry array of {rd, data}; head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter 0..DEPTH.
- Reset (reset==0, asynchronous): pointers and count go to 0.
  - Outputs during and after reset: RegWrite=0, rd=0, WriteData=0, hit1/hit2=0, fwd1/fwd2=0, wb_ready=1.
  - Entry array contents need not be cleared.
- Handshake:
  - wb_ready = (count < DEPTH), derived from registered state only.
  - A request is accepted when wb_valid && wb_ready at a rising edge.
  - wb_ready does not depend on the same-cycle dequeue, so a full queue stalls for one cycle even if it is draining.
- rd==0 filter: an accepted request with wb_rd==0 is consumed but not stored; count and tail are unchanged.
- Drain:
  - When count>0: rd/WriteData present the head entry.
  - RegWrite = (count>0) && rf_ready, combinational from state plus rf_ready.
  - Head advances and count decrements on any edge where RegWrite==1.
- When count==0: rd=0, WriteData=0, RegWrite=0.
- Latency: an accepted request appears on RegWrite no earlier than the following cycle. There is no same-cycle passthrough.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Ordering: strictly FIFO. Two requests to the same rd are written in arrival order.
- Forwarding (combinational over the pending entries, including the head being written this cycle):
  - hitN=1 when any valid entry has rd==q_rsN and q_rsN!=0.
  - fwdN returns the data of the youngest such entry (closest to tail).
  - A request being accepted in the same cycle is not visible until the next cycle.
- Reset mid-operation: all pending entries are discarded. No RegWrite is issued for them, even if rf_ready is high.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (5'd0).
  - a packed writeback-entry typedef {rd, data}, reused by the pipeline stages.
- One natural sub-module: wbq_match, a DEPTH-entry youngest-match priority selector.
  - Inputs: entry array, head, count, query index.
  - Outputs: hit and data.
  - Instantiated twice, once for each lookup port.

Test Plan:
- Reset with wb_valid=1 held → all outputs 0, wb_ready=1. After release, enqueue rd=5, data=0x55 → next cycle RegWrite=1, rd=5, WriteData=0x55, then count back to 0.
- rf_ready=0; enqueue rd=1..4 with data 0x11..0x44 → count=4 and wb_ready=0, fifth request held. Raise rf_ready → writes drain in order 1,2,3,4 over 4 cycles, and the held fifth request is accepted the cycle after count<4.
- rf_ready=0; enqueue rd=7 data=0xA, then rd=7 data=0xB → q_rs1=7 gives hit1=1, fwd1=0xB. q_rs2=0 gives hit2=0, fwd2=0.
- Enqueue rd=0 data=0xFFFF → request accepted, count stays 0, no RegWrite ever issued.
- Queue at count=2 with rf_ready=1 and wb_valid=1 every cycle → count stays 2. Run pointers past DEPTH wrap for ≥10 writes; the write sequence must equal the input sequence.
- rf_ready=0, queue holding 3 entries; assert reset=0 for 1 cycle → count=0 and RegWrite=0 immediately. After release, no stale writes appear with rf_ready=1.
